// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
// Pipeline hazard and stall controller for a 5-stage in-order core.
// Handles three cases, in priority order:
//   1. Data-memory freeze: the MEM stage waits for the data memory.
//   2. Taken branch: the younger instructions are flushed.
//   3. Load-use: the pipeline stalls for one cycle.
// A data-memory wait longer than MAX_WAIT cycles locks the controller in
// TIMEOUT. Only reset leaves TIMEOUT.
// The controller also keeps a saturating count of cycles with the PC held.

module hazard_stall_ctrl #(
  parameter int MAX_WAIT = 15,  // MEM_WAIT cycles allowed before timeout (1..255)
  parameter int CNT_W    = 16   // width of the stall performance counter
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       i_id_rs1,
  input  logic [4:0]       i_id_rs2,
  input  logic             i_id_uses_rs2,
  input  logic             i_idex_mem_read,
  input  logic [4:0]       i_idex_rd,
  input  logic             i_ex_branch_taken,
  input  logic             i_mem_req,
  input  logic             i_mem_ready,
  output logic             o_pc_write,
  output logic             o_if_id_reg_ctrl,
  output logic             o_if_id_flush,
  output logic             o_id_ex_bubble,
  output logic             o_ex_mem_hold,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic             o_timeout_err
);

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] MEM_WAIT = 2'd1;
  localparam logic [1:0] TIMEOUT  = 2'd2;

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic [7:0]       r_wait_cnt;
  logic [7:0]       w_wait_cnt_next;
  logic [7:0]       w_wait_inc;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_mem_freeze;
  logic             w_load_use;

  // Raw hazard conditions. A freeze only matters in RUN or MEM_WAIT, and
  // the state decode below applies that restriction.
  assign w_mem_freeze = i_mem_req & ~i_mem_ready;
  assign w_load_use   = i_idex_mem_read && (i_idex_rd != 5'd0) &&
                        ((i_idex_rd == i_id_rs1) ||
                         (i_id_uses_rs2 && (i_idex_rd == i_id_rs2)));
  assign w_wait_inc   = r_wait_cnt + 8'd1;

  // Output decode and next-state / wait-counter selection.
  always_comb begin
    // NOTE: every output of this block gets a value before the case, so no
    // path through the block leaves a signal unassigned and no latch is inferred.
    o_pc_write       = 1'b1;
    o_if_id_reg_ctrl = 1'b1;
    o_if_id_flush    = 1'b0;
    o_id_ex_bubble   = 1'b0;
    o_ex_mem_hold    = 1'b0;
    w_next_state     = r_state;
    w_wait_cnt_next  = r_wait_cnt;

    case (r_state)
      RUN, MEM_WAIT: begin
        if (w_mem_freeze) begin
          // The whole pipeline freezes. The freeze hides any pending branch,
          // so that branch is acted on in the first unfrozen cycle.
          o_pc_write       = 1'b0;
          o_if_id_reg_ctrl = 1'b0;
          o_ex_mem_hold    = 1'b1;
          if (r_state == RUN) begin
            w_next_state    = MEM_WAIT;
            w_wait_cnt_next = 8'd0;
          end else begin
            w_wait_cnt_next = w_wait_inc;
            w_next_state    = (w_wait_inc >= MAX_WAIT_C) ? TIMEOUT : MEM_WAIT;
          end
        end else begin
          // No freeze: apply the RUN rules in this same cycle.
          w_next_state = RUN;
          if (i_ex_branch_taken) begin
            o_if_id_flush  = 1'b1;
            o_id_ex_bubble = 1'b1;
          end else if (w_load_use) begin
            o_pc_write       = 1'b0;
            o_if_id_reg_ctrl = 1'b0;
            o_id_ex_bubble   = 1'b1;
          end
        end
      end
      TIMEOUT: begin
        // Stop the pipeline until reset.
        o_pc_write       = 1'b0;
        o_if_id_reg_ctrl = 1'b0;
        o_ex_mem_hold    = 1'b1;
        o_id_ex_bubble   = 1'b1;
      end
      default: begin
        w_next_state = RUN;
      end
    endcase
  end

  // State and wait-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= RUN;
      r_wait_cnt <= 8'd0;
    end else begin
      // NOTE: clocked state uses non-blocking assignments, so every register
      // in this block updates from values taken before the clock edge.
      r_state    <= w_next_state;
      r_wait_cnt <= w_wait_cnt_next;
    end
  end

  // Saturating count of cycles with the PC held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (!o_pc_write && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign o_stall_cnt   = r_stall_cnt;
  assign o_timeout_err = (r_state == TIMEOUT);

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed testbench for hazard_stall_ctrl.
// Both DUT instances receive the same inputs:
//   u_a uses the default parameters.
//   u_b uses MAX_WAIT=4 and CNT_W=4, for the timeout and saturation cases.
// Inputs change on the falling edge. Combinational outputs are sampled 1 ns
// later. The counters are sampled 1 ns after the rising edge.

module tb_hazard_stall_ctrl;

  logic       clk;
  logic       rst_n;
  logic [4:0] id_rs1, id_rs2, idex_rd;
  logic       id_uses_rs2, idex_mem_read, br, mem_req, mem_ready;

  logic        a_pc, a_ifid, a_flush, a_bubble, a_hold, a_err;
  logic [15:0] a_cnt;
  logic        b_pc, b_ifid, b_flush, b_bubble, b_hold, b_err;
  logic [3:0]  b_cnt;

  wire [4:0] a_ctl = {a_pc, a_ifid, a_flush, a_bubble, a_hold};
  wire [4:0] b_ctl = {b_pc, b_ifid, b_flush, b_bubble, b_hold};

  // {pc_write, if_id_reg_ctrl, if_id_flush, id_ex_bubble, ex_mem_hold}
  localparam logic [4:0] DEF = 5'b11000;
  localparam logic [4:0] FRZ = 5'b00001;
  localparam logic [4:0] BRF = 5'b11110;
  localparam logic [4:0] LDU = 5'b00010;
  localparam logic [4:0] TMO = 5'b00011;

  int n_cmp = 0;
  int n_err = 0;

  hazard_stall_ctrl u_a (
    .clk(clk), .rst_n(rst_n),
    .i_id_rs1(id_rs1), .i_id_rs2(id_rs2), .i_id_uses_rs2(id_uses_rs2),
    .i_idex_mem_read(idex_mem_read), .i_idex_rd(idex_rd),
    .i_ex_branch_taken(br), .i_mem_req(mem_req), .i_mem_ready(mem_ready),
    .o_pc_write(a_pc), .o_if_id_reg_ctrl(a_ifid), .o_if_id_flush(a_flush),
    .o_id_ex_bubble(a_bubble), .o_ex_mem_hold(a_hold),
    .o_stall_cnt(a_cnt), .o_timeout_err(a_err)
  );

  hazard_stall_ctrl #(.MAX_WAIT(4), .CNT_W(4)) u_b (
    .clk(clk), .rst_n(rst_n),
    .i_id_rs1(id_rs1), .i_id_rs2(id_rs2), .i_id_uses_rs2(id_uses_rs2),
    .i_idex_mem_read(idex_mem_read), .i_idex_rd(idex_rd),
    .i_ex_branch_taken(br), .i_mem_req(mem_req), .i_mem_ready(mem_ready),
    .o_pc_write(b_pc), .o_if_id_reg_ctrl(b_ifid), .o_if_id_flush(b_flush),
    .o_id_ex_bubble(b_bubble), .o_ex_mem_hold(b_hold),
    .o_stall_cnt(b_cnt), .o_timeout_err(b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic set_idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; idex_rd = 5'd0;
    id_uses_rs2 = 1'b0; idex_mem_read = 1'b0; br = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    set_idle();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    set_idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    if (a_cnt !== 16'd0 || a_err !== 1'b0 || a_ctl !== DEF) begin
      $display("FAIL reset_a: cnt=%0d err=%b ctl=%b want cnt=0 err=0 ctl=%b", a_cnt, a_err, a_ctl, DEF);
      n_err++;
    end
    n_cmp++;
    if (b_cnt !== 4'd0 || b_err !== 1'b0 || b_ctl !== DEF) begin
      $display("FAIL reset_b: cnt=%0d err=%b ctl=%b want cnt=0 err=0 ctl=%b", b_cnt, b_err, b_ctl, DEF);
      n_err++;
    end
    n_cmp++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_load_use();
    do_reset();
    // A hazard on rs1 stalls for one cycle.
    idex_mem_read = 1'b1; idex_rd = 5'd5; id_rs1 = 5'd5;
    #1;
    if (a_ctl !== LDU) begin
      $display("FAIL lu_rs1_ctl: got %b want %b", a_ctl, LDU); n_err++;
    end
    n_cmp++;
    @(posedge clk); #1;
    if (a_cnt !== 16'd1) begin
      $display("FAIL lu_rs1_cnt: got %0d want 1", a_cnt); n_err++;
    end
    n_cmp++;
    // After the hazard clears, the outputs return to the defaults.
    @(negedge clk); set_idle(); #1;
    if (a_ctl !== DEF) begin
      $display("FAIL lu_after_ctl: got %b want %b", a_ctl, DEF); n_err++;
    end
    n_cmp++;
    // A load with rd=0 never stalls.
    @(negedge clk);
    idex_mem_read = 1'b1; idex_rd = 5'd0; id_rs1 = 5'd0; #1;
    if (a_ctl !== DEF) begin
      $display("FAIL lu_rd0_ctl: got %b want %b", a_ctl, DEF); n_err++;
    end
    n_cmp++;
    // A match on rs2 stalls only when rs2 is used.
    @(negedge clk);
    idex_mem_read = 1'b1; idex_rd = 5'd7; id_rs1 = 5'd3; id_rs2 = 5'd7; id_uses_rs2 = 1'b0; #1;
    if (a_ctl !== DEF) begin
      $display("FAIL lu_rs2_unused: got %b want %b", a_ctl, DEF); n_err++;
    end
    n_cmp++;
    @(negedge clk);
    id_uses_rs2 = 1'b1; #1;
    if (a_ctl !== LDU) begin
      $display("FAIL lu_rs2_used: got %b want %b", a_ctl, LDU); n_err++;
    end
    n_cmp++;
    // A match is no hazard unless the EX instruction is a load.
    @(negedge clk);
    idex_mem_read = 1'b0; #1;
    if (a_ctl !== DEF) begin
      $display("FAIL lu_not_load: got %b want %b", a_ctl, DEF); n_err++;
    end
    n_cmp++;
    @(posedge clk); #1;
    if (a_cnt !== 16'd2) begin
      $display("FAIL lu_total_cnt: got %0d want 2", a_cnt); n_err++;
    end
    n_cmp++;
  endtask

  task automatic test_branch_load_use();
    do_reset();
    br = 1'b1; idex_mem_read = 1'b1; idex_rd = 5'd9; id_rs1 = 5'd9; #1;
    if (a_ctl !== BRF) begin
      $display("FAIL br_lu_ctl: got %b want %b", a_ctl, BRF); n_err++;
    end
    n_cmp++;
    @(posedge clk); #1;
    if (a_cnt !== 16'd0) begin
      $display("FAIL br_lu_cnt: got %0d want 0", a_cnt); n_err++;
    end
    n_cmp++;
  endtask

  task automatic test_mem_wait();
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      mem_req = 1'b1; mem_ready = 1'b0; #1;
      if (a_ctl !== FRZ) begin
        $display("FAIL memwait_frz%0d: got %b want %b", i, a_ctl, FRZ); n_err++;
      end
      n_cmp++;
      @(negedge clk);
    end
    mem_ready = 1'b1; #1;
    if (a_ctl !== DEF) begin
      $display("FAIL memwait_release: got %b want %b", a_ctl, DEF); n_err++;
    end
    n_cmp++;
    @(posedge clk); #1;
    if (a_cnt !== 16'd3) begin
      $display("FAIL memwait_cnt: got %0d want 3", a_cnt); n_err++;
    end
    n_cmp++;
    // The controller is back in RUN, so a new freeze starts a fresh wait.
    @(negedge clk); set_idle(); #1;
    if (a_ctl !== DEF || a_err !== 1'b0) begin
      $display("FAIL memwait_run: ctl=%b err=%b want %b err=0", a_ctl, a_err, DEF); n_err++;
    end
    n_cmp++;
  endtask

  task automatic test_timeout();
    do_reset();
    // Cycle 1 is in RUN. Cycles 2..5 are counted MEM_WAIT cycles 1..4.
    for (int i = 1; i <= 5; i++) begin
      mem_req = 1'b1; mem_ready = 1'b0; #1;
      if (b_ctl !== FRZ || b_err !== 1'b0) begin
        $display("FAIL to_frz%0d: ctl=%b err=%b want %b err=0", i, b_ctl, b_err, FRZ); n_err++;
      end
      n_cmp++;
      @(negedge clk);
    end
    #1;
    if (b_ctl !== TMO || b_err !== 1'b1) begin
      $display("FAIL to_enter: ctl=%b err=%b want %b err=1", b_ctl, b_err, TMO); n_err++;
    end
    n_cmp++;
    if (a_ctl !== FRZ || a_err !== 1'b0) begin
      $display("FAIL to_a_still_wait: ctl=%b err=%b want %b err=0", a_ctl, a_err, FRZ); n_err++;
    end
    n_cmp++;
    @(posedge clk); #1;
    if (b_cnt !== 4'd6) begin
      $display("FAIL to_cnt: got %0d want 6", b_cnt); n_err++;
    end
    n_cmp++;
    // mem_ready does not release TIMEOUT.
    @(negedge clk); mem_ready = 1'b1;
    @(negedge clk); set_idle(); #1;
    if (b_ctl !== TMO || b_err !== 1'b1) begin
      $display("FAIL to_sticky: ctl=%b err=%b want %b err=1", b_ctl, b_err, TMO); n_err++;
    end
    n_cmp++;
    // Reset clears the timeout at once, with no clock edge needed.
    #2 rst_n = 1'b0; #1;
    if (b_err !== 1'b0 || b_cnt !== 4'd0 || b_ctl !== DEF) begin
      $display("FAIL to_async_rst: err=%b cnt=%0d ctl=%b want err=0 cnt=0 ctl=%b", b_err, b_cnt, b_ctl, DEF); n_err++;
    end
    n_cmp++;
    @(negedge clk); rst_n = 1'b1; #1;
    if (b_ctl !== DEF || b_err !== 1'b0) begin
      $display("FAIL to_after_rst: ctl=%b err=%b want %b err=0", b_ctl, b_err, DEF); n_err++;
    end
    n_cmp++;
  endtask

  task automatic test_branch_freeze();
    do_reset();
    for (int i = 1; i <= 2; i++) begin
      br = 1'b1; mem_req = 1'b1; mem_ready = 1'b0; #1;
      if (a_ctl !== FRZ) begin
        $display("FAIL brfrz_hold%0d: got %b want %b", i, a_ctl, FRZ); n_err++;
      end
      n_cmp++;
      @(negedge clk);
    end
    mem_ready = 1'b1; #1;
    if (a_ctl !== BRF) begin
      $display("FAIL brfrz_flush: got %b want %b", a_ctl, BRF); n_err++;
    end
    n_cmp++;
    @(posedge clk); #1;
    if (a_cnt !== 16'd2) begin
      $display("FAIL brfrz_cnt: got %0d want 2", a_cnt); n_err++;
    end
    n_cmp++;
  endtask

  task automatic test_saturation();
    do_reset();
    idex_mem_read = 1'b1; idex_rd = 5'd12; id_rs1 = 5'd12;
    repeat (20) @(posedge clk);
    #1;
    if (b_cnt !== 4'd15) begin
      $display("FAIL sat_b_cnt: got %0d want 15", b_cnt); n_err++;
    end
    n_cmp++;
    if (a_cnt !== 16'd20) begin
      $display("FAIL sat_a_cnt: got %0d want 20", a_cnt); n_err++;
    end
    n_cmp++;
    if (b_ctl !== LDU) begin
      $display("FAIL sat_b_ctl: got %b want %b", b_ctl, LDU); n_err++;
    end
    n_cmp++;
  endtask

  initial begin
    set_idle();
    rst_n = 1'b0;
    test_reset();
    test_load_use();
    test_branch_load_use();
    test_mem_wait();
    test_timeout();
    test_branch_freeze();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

Interface
REQ-001 Parameter: MAX_WAIT, 15, cycles permitted in MEM_WAIT before timeout (range 1..255).
REQ-002 Parameter: CNT_W, 16, width of stall performance counter.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
REQ-006 id_uses_rs2  in  1  ID instruction reads rs2.
REQ-007 idex_mem_read  in  1  instruction in EX is a load.
REQ-008 idex_rd  in  5  destination register of the instruction in EX.
REQ-009 ex_branch_taken  in  1  branch/jump resolved taken in EX this cycle.
REQ-010 mem_req  in  1  instruction in MEM accesses data memory this cycle.
REQ-011 mem_ready  in  1  data memory completes the access this cycle.
REQ-012 pc_write  out  1  PC update enable.
REQ-013 if_id_reg_ctrl  out  1  IF/ID pipeline register load enable.
REQ-014 if_id_flush  out  1  IF/ID register loads a NOP.
REQ-015 id_ex_bubble  out  1  ID/EX register loads a NOP.
REQ-016 ex_mem_hold  out  1  EX/MEM and MEM/WB registers hold their values.
REQ-017 stall_cnt  out  CNT_W  count of cycles with pc_write=0.
REQ-018 timeout_err  out  1  sticky memory-timeout flag.

Function
REQ-019 The block SHALL implement FSM states RUN, MEM_WAIT and TIMEOUT, each with a distinct encoding.
REQ-020 mem_freeze SHALL be defined as mem_req=1 and mem_ready=0, evaluated in RUN or MEM_WAIT.
REQ-021 load_use SHALL be defined as idex_mem_read=1, idex_rd!=0, and (idex_rd==id_rs1 or (id_uses_rs2=1 and idex_rd==id_rs2)).
REQ-022 Default outputs SHALL be pc_write=1, if_id_reg_ctrl=1, if_id_flush=0, id_ex_bubble=0, ex_mem_hold=0; all output decode SHALL be combinational from state and inputs.
REQ-023 Priority in RUN or MEM_WAIT SHALL be mem_freeze > ex_branch_taken > load_use.
REQ-024 On mem_freeze: pc_write=0, if_id_reg_ctrl=0, ex_mem_hold=1, id_ex_bubble=0, if_id_flush=0; next state MEM_WAIT.
REQ-025 On ex_branch_taken without mem_freeze: pc_write=1, if_id_reg_ctrl=1, if_id_flush=1, id_ex_bubble=1; next state RUN.
REQ-026 On load_use without mem_freeze or ex_branch_taken: pc_write=0, if_id_reg_ctrl=0, id_ex_bubble=1; next state RUN; the stall lasts exactly one cycle.
REQ-027 In MEM_WAIT with mem_ready=1: outputs SHALL follow the RUN rules (REQ-025/026/default) in the same cycle; next state RUN.
REQ-028 wait_cnt (8-bit internal) SHALL clear on entry to MEM_WAIT and increment each MEM_WAIT cycle with mem_ready=0.
REQ-029 When wait_cnt reaches MAX_WAIT while in MEM_WAIT with mem_ready=0, the next state SHALL be TIMEOUT.
REQ-030 In TIMEOUT: pc_write=0, if_id_reg_ctrl=0, ex_mem_hold=1, id_ex_bubble=1; timeout_err=1; exit only via reset.
REQ-031 stall_cnt SHALL increment by 1 on every cycle with pc_write=0 and saturate at all-ones.
REQ-032 ex_branch_taken held asserted during a freeze SHALL be acted on in the first unfrozen cycle.

Reset
REQ-033 While rst_n=0: state=RUN, wait_cnt=0, stall_cnt=0, timeout_err=0, regardless of clk.
REQ-034 Reset asserted in MEM_WAIT or TIMEOUT SHALL return to RUN with counters cleared; on the first cycle after release, outputs SHALL be defaults if inputs are idle.

Verification
REQ-035 Load-use: idex_mem_read=1, idex_rd=5, id_rs1=5 for one cycle -> pc_write=0, if_id_reg_ctrl=0, id_ex_bubble=1 that cycle; stall_cnt 0->1; defaults next cycle; repeat with idex_rd=0 -> no stall.
REQ-036 Branch plus load-use same cycle: ex_branch_taken=1 and load_use=1 -> if_id_flush=1, id_ex_bubble=1, pc_write=1; stall_cnt unchanged.
REQ-037 Memory wait: mem_req=1, mem_ready=0 for 3 cycles then mem_ready=1 -> freeze outputs for 3 cycles, release on the 4th; state RUN; stall_cnt=3.
REQ-038 Timeout: MAX_WAIT=4, mem_req=1, mem_ready held 0 -> TIMEOUT entered after the 4th counted MEM_WAIT cycle; timeout_err=1 stays set; rst_n pulse clears to RUN with timeout_err=0.
REQ-039 Branch during freeze: ex_branch_taken=1 with mem_freeze for 2 cycles -> no flush for 2 cycles; flush in the first cycle mem_ready=1.
REQ-040 Saturation: CNT_W=4, hold load_use 20 cycles -> stall_cnt stops at 15.
